fetch_rtl_unit: RTL and testbench

Instruction-fetch program-counter unit for the single-cycle processor. It holds the 32-bit PC, advances it by one word per clock, and loads a redirect target (branch/jump) when requested. The PC drives the instruction memory address; the instruction memory is external to this block.

---
 rtl/fetch_rtl_unit_if.sv | 25 ++
 rtl/fetch_rtl_unit.sv | 35 +++
 tb/tb_fetch_rtl_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_rtl_unit_if.sv
// Fetch-side bus between the PC unit and the core: PC outputs toward
// instruction memory and the datapath, plus the redirect request.
interface fetch_rtl_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_step;
  logic             pc_misaligned;
  logic             pc_update;
  logic [WIDTH-1:0] pc_new;

  modport master (
    input  pc,
    input  pc_plus_step,
    input  pc_misaligned,
    output pc_update,
    output pc_new
  );

  modport slave (
    output pc,
    output pc_plus_step,
    output pc_misaligned,
    input  pc_update,
    input  pc_new
  );
endinterface

// File: rtl/fetch_rtl_unit.sv
// Program-counter register for the single-cycle core: steps by PC_STEP each
// clock, loads a redirect target when requested, resets asynchronously.
module fetch_rtl_unit #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  fetch_rtl_unit_if.slave   fetch
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_seq;

  // Modulo-2^WIDTH add; wrap from the top word to zero is intentional.
  assign pc_seq = pc_q + STEP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (fetch.pc_update) begin
      pc_q <= fetch.pc_new;
    end else begin
      pc_q <= pc_seq;
    end
  end

  assign fetch.pc            = pc_q;
  assign fetch.pc_plus_step  = pc_seq;
  assign fetch.pc_misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_fetch_rtl_unit.sv
// Scoreboard bench for fetch_rtl_unit: expected PC values are queued when
// each edge is driven and popped when the registered PC is sampled.
module tb_fetch_rtl_unit;

  logic clk;
  logic reset;

  fetch_rtl_unit_if #(.WIDTH(32)) bus ();

  fetch_rtl_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fetch (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] imem[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one edge and queue the PC the model expects after it.
  task automatic advance(input logic upd, input logic [31:0] tgt);
    bus.pc_update = upd;
    bus.pc_new    = tgt;
    model_pc      = upd ? tgt : model_pc + 32'd4;
    exp_q.push_back(model_pc);
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset = 1'b1;
    bus.pc_update = 1'b0;
    bus.pc_new = 32'hDEAD_BEEF;
    #2 reset = 1'b0;
    #1;
    model_pc = 32'h0;
    tests_run++;
    if (bus.pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected %h", bus.pc, 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (bus.pc !== e || bus.pc_plus_step !== 32'd4 || bus.pc_misaligned !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold: got pc=%h pps=%h mis=%b expected pc=%h pps=%h mis=0",
                 bus.pc, bus.pc_plus_step, bus.pc_misaligned, e, 32'd4);
      end
    end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) imem[i] = 32'(i + 1);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd = (bus.pc[31:2] < 8) ? imem[bus.pc[4:2]] : 32'hFFFF_FFFF;
      tests_run++;
      if (rd !== 32'(i + 1)) begin
        tests_failed++;
        $display("FAIL seq_imem: got %0d expected %0d", rd, i + 1);
      end
      advance(1'b0, 32'h0);
      e = exp_q.pop_front();
      tests_run++;
      if (bus.pc !== e || bus.pc !== 32'(4 * (i + 1))) begin
        tests_failed++;
        $display("FAIL seq_pc: got %h expected %h", bus.pc, 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    advance(1'b1, 32'd128);
    advance(1'b1, 32'd128);
    advance(1'b0, 32'h0);
    advance(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      // Queue is drained after all edges, so check the final PC against the last entry.
      e = exp_q.pop_front();
      if (i == 3) begin
        tests_run++;
        if (bus.pc !== e || e !== 32'd136) begin
          tests_failed++;
          $display("FAIL redirect_seq: got %h expected %h", bus.pc, 32'd136);
        end
      end
    end
  endtask

  task automatic test_redirect_stepwise();
    logic [31:0] e;
    logic [31:0] want[4] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
    logic        upd[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      advance(upd[i], 32'h0000_0200);
      e = exp_q.pop_front();
      tests_run++;
      if (bus.pc !== e || bus.pc !== want[i]) begin
        tests_failed++;
        $display("FAIL redirect_step%0d: got %h expected %h", i, bus.pc, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    advance(1'b1, 32'd136);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pc !== 32'd136) begin
      tests_failed++;
      $display("FAIL areset_pre: got %h expected %h", bus.pc, 32'd136);
    end
    bus.pc_update = 1'b1;
    bus.pc_new    = 32'h0000_5550;
    #3 reset = 1'b0;
    #1;
    model_pc = 32'h0;
    tests_run++;
    if (bus.pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_mid: got %h expected %h", bus.pc, 32'h0);
    end
    #1 reset = 1'b1;
    advance(1'b0, 32'h0);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pc !== e || bus.pc !== 32'd4) begin
      tests_failed++;
      $display("FAIL areset_release: got %h expected %h", bus.pc, 32'd4);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    advance(1'b1, 32'hFFFF_FFFC);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pc !== e || bus.pc_plus_step !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_load: got pc=%h pps=%h expected pc=%h pps=%h",
               bus.pc, bus.pc_plus_step, e, 32'h0);
    end
    advance(1'b0, 32'h0);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pc !== e || bus.pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_inc: got %h expected %h", bus.pc, 32'h0);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] e;
    advance(1'b1, 32'h0000_0102);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pc !== e || bus.pc_misaligned !== 1'b1 || bus.pc_plus_step !== 32'h0000_0106) begin
      tests_failed++;
      $display("FAIL misaligned_load: got pc=%h mis=%b pps=%h expected pc=%h mis=1 pps=%h",
               bus.pc, bus.pc_misaligned, bus.pc_plus_step, e, 32'h0000_0106);
    end
    advance(1'b0, 32'h0);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pc !== e || bus.pc !== 32'h0000_0106 || bus.pc_misaligned !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_inc: got pc=%h mis=%b expected pc=%h mis=1",
               bus.pc, bus.pc_misaligned, 32'h0000_0106);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] tgts[3] = '{32'h0000_0040, 32'h0000_0080, 32'h0000_1000};
    for (int i = 0; i < 3; i++) begin
      advance(1'b1, tgts[i]);
      e = exp_q.pop_front();
      tests_run++;
      if (bus.pc !== e || bus.pc !== tgts[i]) begin
        tests_failed++;
        $display("FAIL b2b_redirect%0d: got %h expected %h", i, bus.pc, tgts[i]);
      end
    end
    advance(1'b0, 32'h0);
    e = exp_q.pop_front();
    tests_run++;
    if (bus.pc !== e || bus.pc !== 32'h0000_1004) begin
      tests_failed++;
      $display("FAIL b2b_release: got %h expected %h", bus.pc, 32'h0000_1004);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_pc     = 32'h0;
    test_reset();
    test_sequential();
    test_redirect();
    test_redirect_stepwise();
    test_async_reset();
    test_wrap();
    test_misaligned();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
